rs232_tx_arbiter: RTL
=====================

Name: rs232_tx_arbiter

Overview:
Round-robin scheduler that shares one RS232 byte transmitter among NUM_REQ byte-stream requesters (command responder, debug monitor, echo path, etc.).
A grant is held for a whole packet, delimited by a per-requester last flag, so packets from different requesters never interleave on the serial line.
The block sits between the requesters and the transmitter's byte-load interface (tx_data / tx_start / tx_busy).
It adds a watchdog for a transmitter that never accepts and for a granted requester that stalls mid-packet.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACCEPT_TIMEOUT, 16, max cycles from tx_start to tx_busy rising before an error is flagged
HOLD_TIMEOUT, 1_000_000, max idle cycles with the grant held and no req_valid before the grant is revoked

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*8  flattened bytes; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  byte being offered is the packet's final byte
req_ready  out  NUM_REQ  registered one-cycle pulse: byte taken from requester i
tx_data  out  8  byte to transmitter, held stable until the next load
tx_start  out  1  registered one-cycle load pulse to transmitter
tx_busy  in  1  transmitter shifting a frame (start, data, stop)
grant  out  NUM_REQ  one-hot current owner; 0 when idle
timeout_err  out  2  pulse: bit0 accept timeout, bit1 hold timeout

Behaviour:
- Reset (async): state IDLE. req_ready=0, tx_start=0, tx_data=0, grant=0, timeout_err=0. RR pointer=NUM_REQ-1, so req0 has first priority. Counters cleared. A frame already in flight in the transmitter is not affected.
- A byte transfers on any edge where the arbiter asserts req_ready[i]. The requester must hold req_valid, req_data and req_last stable until it sees req_ready.
- State IDLE:
  - If any req_valid is set, pick the first set bit scanning from pointer+1 upward, with wrap.
  - Set grant to that requester, set pointer to its index, go to SEND.
  - No valid requests: stay in IDLE.
- State SEND (g = granted index):
  - If req_valid[g] && !tx_busy, then in the same edge:
    - tx_data <= req_data[g]; tx_start <= 1; req_ready[g] <= 1;
    - last_q <= req_last[g]; clear the counter; go to WAIT_ACC.
  - If req_valid[g]=0, increment the hold counter.
    - When it reaches HOLD_TIMEOUT-1: pulse timeout_err[1], grant <= 0, go to IDLE.
  - Valid requests from other requesters are ignored while a grant is held.
- State WAIT_ACC:
  - tx_busy=1: go to WAIT_DONE.
  - Counter reaches ACCEPT_TIMEOUT-1 with no tx_busy: pulse timeout_err[0], grant <= 0, go to IDLE. The byte counts as consumed.
- State WAIT_DONE:
  - Wait for tx_busy=0.
  - Then: last_q=1 → grant <= 0, go to IDLE; last_q=0 → go to SEND.
- Latency:
  - IDLE→SEND: 1 cycle.
  - SEND with valid → tx_start: same edge.
  - Back-to-back bytes: one frame time plus 2–3 cycles.
  - Release to next grant: 1 cycle via IDLE.
- Pulses: tx_start, req_ready and timeout_err are high for exactly one cycle. They default to 0 every cycle unless asserted.
- Simultaneous requests in IDLE: RR order only. Example: pointer=1 with req 0 and 2 valid → grant 2.
- Wrap-around: pointer=NUM_REQ-1 scans from 0.
- Single-byte packet (req_last on first byte): grant released after that byte.
- tx_busy already high in SEND (frame started externally): wait without loading and without incrementing the hold counter.
- Counters saturate; widths are $clog2 of the larger timeout.
- Reset asserted mid-packet: return to IDLE immediately. The rest of the packet is delivered only if the requester re-requests.

Decomposition:
- Shared package/header holds:
  - state encodings: ST_IDLE=2'b00, ST_SEND=2'b01, ST_WAIT_ACC=2'b10, ST_WAIT_DONE=2'b11;
  - the timeout_err bit indices.
- One natural sub-module, rr_pick: combinational round-robin priority encoder (req vector + pointer → one-hot + index + any). It is reusable by other shared-resource arbiters.

Test Plan:
- Reset, then req0 offers a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), with a transmitter model busy for 10 cycles per byte.
  - Required: grant=0001 throughout.
  - Required: exactly 3 tx_start pulses with tx_data 41, 42, 43 and 3 req_ready[0] pulses.
  - Required: grant=0 after the final tx_busy fall.
- req1 and req3 both valid from IDLE, pointer=0, each sending a 2-byte packet.
  - Required: req1's packet transmits completely first, then req3's.
  - Required: no interleaving on tx_data.
- Wrap check: pointer=3 with req0 and req2 valid → grant 0001 first.
- Transmitter model never raises tx_busy after a load of 0x55.
  - Required: timeout_err[0] pulses exactly ACCEPT_TIMEOUT cycles after tx_start.
  - Required: grant=0, then the arbiter serves the next requester normally.
- req2 granted, sends one non-last byte, then drops valid. Run with HOLD_TIMEOUT=8.
  - Required: timeout_err[1] pulses 8 cycles after entry to SEND.
  - Required: grant released; pending req0 granted on the next cycle.
- Reset asserted during WAIT_DONE of a multi-byte packet.
  - Required: all outputs return to their reset values immediately.
  - Required: the next grant goes to req0 first, per the reset pointer.

Source files
------------

// File: rtl/rs232_tx_arbiter_pkg.sv
// rs232_tx_arbiter_pkg
// Shared definitions for the RS232 transmitter arbiter: FSM state encoding,
// bit positions inside timeout_err, and the timeout counter width helper.
// No ports (package).
package rs232_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SEND      = 2'b01,
    ST_WAIT_ACC  = 2'b10,
    ST_WAIT_DONE = 2'b11
  } state_t;

  localparam int ERR_ACCEPT = 0;
  localparam int ERR_HOLD   = 1;

  // One counter serves both timeouts, so it is sized for the larger one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder. Scans the request vector
// starting one position above ptr, wrapping at N-1, and reports the first
// set bit.
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  index of the most recently served requester
//   onehot out N   one-hot winner (0 when nothing requested)
//   idx    out IW  winner index (0 when nothing requested)
//   any    out 1   at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
// Shares one RS232 byte transmitter among NUM_REQ byte-stream requesters.
// The grant is held for a whole packet (closed by req_last) so packets never
// interleave on the line. Watchdogs revoke the grant when the transmitter
// never accepts a load or the owner stalls mid-packet.
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   req_valid/req_last    per-requester byte available / final byte of packet
//   req_data              flattened bytes, requester i on [8i+7:8i]
//   req_ready             one-cycle pulse: byte taken from requester i
//   tx_data/tx_start      byte and one-cycle load pulse to the transmitter
//   tx_busy               transmitter is shifting a frame
//   grant                 one-hot owner, 0 when idle
//   timeout_err           pulse: [0] accept timeout, [1] hold timeout
//
// state        | meaning
// ST_IDLE      | no owner; arbitrate among valid requesters
// ST_SEND      | owner held; load its next byte once transmitter is free
// ST_WAIT_ACC  | byte loaded; wait for tx_busy to rise (accept watchdog)
// ST_WAIT_DONE | frame shifting; wait for tx_busy to fall
module rs232_tx_arbiter
  import rs232_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT   = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic [1:0]           timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = cnt_width(ACCEPT_TIMEOUT, HOLD_TIMEOUT);
  localparam logic [CW-1:0] ACC_LAST  = CW'(ACCEPT_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST   = IW'(NUM_REQ - 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [CW-1:0]      cnt;
  logic               last_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gidx == IW'(i)) sel_data = req_data[8*i +: 8];
  end

  assign sel_valid = req_valid[gidx];
  assign sel_last  = req_last[gidx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= PTR_RST;
      gidx        <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      grant       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= '0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      timeout_err <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_onehot;
            gidx  <= pick_idx;
            ptr   <= pick_idx;
            cnt   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A frame started by someone else freezes both loading and the
          // hold watchdog until the line is free again.
          if (!tx_busy) begin
            if (sel_valid) begin
              tx_data         <= sel_data;
              tx_start        <= 1'b1;
              req_ready[gidx] <= 1'b1;
              last_q          <= sel_last;
              cnt             <= '0;
              state           <= ST_WAIT_ACC;
            end else if (cnt == HOLD_LAST) begin
              timeout_err[ERR_HOLD] <= 1'b1;
              grant                 <= '0;
              cnt                   <= '0;
              state                 <= ST_IDLE;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WAIT_ACC: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt == ACC_LAST) begin
            // The byte was already handed off via req_ready; it is dropped.
            timeout_err[ERR_ACCEPT] <= 1'b1;
            grant                   <= '0;
            cnt                     <= '0;
            state                   <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            cnt <= '0;
            if (last_q) begin
              grant <= '0;
              state <= ST_IDLE;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
